muldiv_sequencer: RTL and testbench

Multi-cycle sequencer and iterative engine for the RV32M operations (ALU control codes 01011–10010). It sits beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time and raises a stall while it iterates. It returns a single 32-bit result with a one-cycle valid pulse.

---
 rtl/rv32_pkg.sv | 33 +++
 rtl/muldiv_core.sv | 112 +++++++++++
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Purpose: shared RV32 execute-stage definitions. Holds the ALU control codes
// for the M-extension operations, the muldiv sequencer state enum and a
// small decode helper.
package rv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_CTRL_W = 5;
  localparam int unsigned CNT_W      = 5;

  // ALU control codes for the M extension (matches the decoder encoding)
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 5'b01011;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULH   = 5'b01100;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHSU = 5'b01101;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULHU  = 5'b01110;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIV    = 5'b01111;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIVU   = 5'b10000;
  localparam logic [ALU_CTRL_W-1:0] ALU_REM    = 5'b10001;
  localparam logic [ALU_CTRL_W-1:0] ALU_REMU   = 5'b10010;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  // True for any code handled by the muldiv sequencer
  function automatic logic is_muldiv_op(input logic [ALU_CTRL_W-1:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Purpose: iteration datapath for the muldiv sequencer. Works on unsigned
// magnitudes only; one shift-add (multiply) or one restoring step (divide)
// per step_i.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : load operands, select mode, counter <= 31
//   step_i    : perform one iteration
//   div_i     : mode at load (1 = divide, 0 = multiply)
//   a_i, b_i  : magnitudes (multiplicand/dividend, multiplier/divisor)
//   prod_o    : 64-bit product
//   quo_o     : 32-bit quotient
//   rem_o     : 32-bit remainder
//   last_o    : current step is the final one (counter == 0)
module muldiv_core
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   rem_o,
  output logic              last_o
);

  logic              div_q,  div_d;
  logic [XLEN-1:0]   m_q,    m_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   quo_q,  quo_d;
  logic [XLEN-1:0]   rem_q,  rem_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic              fits;

  // Next-state for one load or one iteration
  always_comb begin
    div_d  = div_q;
    m_d    = m_q;
    prod_d = prod_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;

    // Multiply: add multiplicand into the upper half, keep the carry, shift right
    add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, m_q};
    // Divide: bring the next dividend bit into the partial remainder
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = shifted >= {1'b0, m_q};

    if (load_i) begin
      div_d = div_i;
      cnt_d = CNT_W'(XLEN - 1);
      rem_d = '0;
      if (div_i) begin
        m_d    = b_i;
        quo_d  = a_i;
        prod_d = '0;
      end else begin
        m_d    = a_i;
        quo_d  = '0;
        prod_d = {{XLEN{1'b0}}, b_i};
      end
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        // Remainder after subtraction is below the divisor, so 32 bits suffice
        if (fits) begin
          rem_d = shifted[XLEN-1:0] - m_q;
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
      end else if (prod_q[0]) begin
        prod_d = {add_sum, prod_q[XLEN-1:1]};
      end else begin
        prod_d = {1'b0, prod_q[2*XLEN-1:1]};
      end
    end
  end

  // Iteration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= 1'b0;
      m_q    <= '0;
      prod_q <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      div_q  <= div_d;
      m_q    <= m_d;
      prod_q <= prod_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end

  assign prod_o = prod_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Purpose: multi-cycle sequencer for RV32M operations. Accepts one operation
// at a time, stalls the pipeline while iterating, and returns a 32-bit result
// with a one-cycle valid pulse.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : execute stage presents an operation
//   req_ready   : sequencer idle and able to accept
//   alu_ctrl    : operation code (MUL..REMU)
//   op_a, op_b  : rs1 / rs2 operands
//   flush       : abandon any in-flight operation
//   busy        : pipeline stall
//   resp_valid  : one-cycle result pulse
//   result      : result, held until overwritten by a later operation
module muldiv_sequencer
  import rv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]       op_a,
  input  logic [XLEN-1:0]       op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       result
);

  muldiv_state_e         state_q,   state_d;
  logic [ALU_CTRL_W-1:0] op_q,      op_d;
  logic [XLEN-1:0]       a_q,       a_d;
  logic [XLEN-1:0]       b_q,       b_d;
  logic                  neg_q,     neg_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]       result_q,  result_d;

  logic                  core_load;
  logic                  core_step;
  logic                  core_div;
  logic [XLEN-1:0]       a_mag;
  logic [XLEN-1:0]       b_mag;
  logic [2*XLEN-1:0]     core_prod;
  logic [XLEN-1:0]       core_quo;
  logic [XLEN-1:0]       core_rem;
  logic                  core_last;

  logic                  a_signed, b_signed, a_neg, b_neg;
  logic                  is_rem, div_zero, sgn_ovf;
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       quo_fix, rem_fix;

  muldiv_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load_i (core_load),
    .step_i (core_step),
    .div_i  (core_div),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .prod_o (core_prod),
    .quo_o  (core_quo),
    .rem_o  (core_rem),
    .last_o (core_last)
  );

  // Operand decode on the latched operation
  always_comb begin
    a_signed = (op_q == ALU_DIV) || (op_q == ALU_REM) ||
               (op_q == ALU_MULH) || (op_q == ALU_MULHSU);
    b_signed = (op_q == ALU_DIV) || (op_q == ALU_REM) || (op_q == ALU_MULH);
    a_neg    = a_signed && a_q[XLEN-1];
    b_neg    = b_signed && b_q[XLEN-1];
    a_mag    = a_neg ? (XLEN'(0) - a_q) : a_q;
    b_mag    = b_neg ? (XLEN'(0) - b_q) : b_q;
    core_div = (op_q >= ALU_DIV);
    is_rem   = (op_q == ALU_REM) || (op_q == ALU_REMU);
    div_zero = core_div && (b_q == '0);
    sgn_ovf  = ((op_q == ALU_DIV) || (op_q == ALU_REM)) &&
               (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    prod_fix = neg_q ? ((2*XLEN)'(0) - core_prod) : core_prod;
    quo_fix  = neg_q ? (XLEN'(0) - core_quo) : core_quo;
    rem_fix  = neg_rem_q ? (XLEN'(0) - core_rem) : core_rem;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush && is_muldiv_op(alu_ctrl)) begin
          state_d = PREP;
          op_d    = alu_ctrl;
          a_d     = op_a;
          b_d     = op_b;
        end
      end
      PREP: begin
        neg_d     = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        if (div_zero) begin
          result_d = is_rem ? a_q : '1;
          state_d  = DONE;
        end else if (sgn_ovf) begin
          result_d = is_rem ? '0 : a_q;
          state_d  = DONE;
        end else begin
          core_load = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (op_q == ALU_MUL) begin
          result_d = prod_fix[XLEN-1:0];
        end else if (!core_div) begin
          result_d = prod_fix[2*XLEN-1:XLEN];
        end else if (is_rem) begin
          result_d = rem_fix;
        end else begin
          result_d = quo_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush abandons the operation without touching the visible result
    if (flush && (state_q != IDLE)) begin
      state_d   = IDLE;
      result_d  = result_q;
      core_load = 1'b0;
      core_step = 1'b0;
    end
  end

  // State and operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Handshake outputs decode state only
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign result     = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Purpose: directed self-checking bench for muldiv_sequencer. Expected results
// and response cycles are queued at issue and checked by a response monitor.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] result;

  localparam logic [4:0] C_MUL    = 5'b01011;
  localparam logic [4:0] C_MULH   = 5'b01100;
  localparam logic [4:0] C_MULHSU = 5'b01101;
  localparam logic [4:0] C_MULHU  = 5'b01110;
  localparam logic [4:0] C_DIV    = 5'b01111;
  localparam logic [4:0] C_DIVU   = 5'b10000;
  localparam logic [4:0] C_REM    = 5'b10001;
  localparam logic [4:0] C_REMU   = 5'b10010;

  localparam int LAT_NORM = 35;
  localparam int LAT_SPEC = 2;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  muldiv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one request in the current (low-clock) phase; call after a negedge
  task automatic issue(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push,
                       output int t0);
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    alu_ctrl  = code;
    op_a      = a;
    op_b      = b;
    t0        = cyc;
    if (push) sbq.push_back('{res: exp, cyc: t0 + lat});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    alu_ctrl  = 5'b00000;
  endtask

  // Wait (bounded) for all queued responses to arrive
  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int t0;
    @(negedge clk);
    issue(code, a, b, exp, lat, 1'b1, t0);
    drain(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    rst       = 1'b1;
    req_valid = 1'b0;
    alu_ctrl  = 5'b00000;
    op_a      = '0;
    op_b      = '0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;

    // MUL 7 * -3 with busy profile over cycles 1..36
    @(negedge clk);
    issue(C_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM, 1'b1, t0);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_c%0d", k), 32'(busy), (k <= 35) ? 32'd1 : 32'd0);
    end
    chk("mul_ready_after_done", 32'(req_ready), 32'd1);
    drain(5);

    run_op(C_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_NORM);
    run_op(C_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORM);
    run_op(C_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_NORM);
    run_op(C_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_NORM);
    run_op(C_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_NORM);
    run_op(C_REMU,   32'd100,       32'd7,         32'd2,         LAT_NORM);

    // Special cases complete in cycle 2
    run_op(C_DIVU, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, LAT_SPEC);
    run_op(C_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678, LAT_SPEC);
    run_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC);
    run_op(C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         LAT_SPEC);
    run_op(C_DIVU, 32'd100,       32'd7,         32'd14,        LAT_NORM);

    // Flush a DIV in cycle 10, then MUL 3*5 in cycle 11
    @(negedge clk);
    issue(C_DIV, 32'd1000, 32'd3, 32'd0, LAT_NORM, 1'b0, t0);
    repeat (10) @(negedge clk);
    chk("flush_busy_c10", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready_c11", 32'(req_ready), 32'd1);
    chk("flush_busy_c11", 32'(busy), 32'd0);
    chk("flush_result_kept", result, 32'd14);
    chk("flush_cycle", 32'(cyc - t0), 32'd11);
    issue(C_MUL, 32'd3, 32'd5, 32'd15, LAT_NORM, 1'b1, t1);
    drain(60);

    // Flush alongside req_valid blocks acceptance
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    alu_ctrl  = C_MUL;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("flush_req_busy", 32'(busy), 32'd0);

    // Unsupported code is ignored
    req_valid = 1'b1;
    alu_ctrl  = 5'b00000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("bad_code_busy", 32'(busy), 32'd0);
    chk("bad_code_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("bad_code_busy_later", 32'(busy), 32'd0);

    // Reset in cycle 20 of a MUL
    @(negedge clk);
    issue(C_MUL, 32'd9, 32'd9, 32'd0, LAT_NORM, 1'b0, t0);
    repeat (20) @(negedge clk);
    chk("rst_mid_busy_c20", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_result", result, 32'h0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_resp_busy", 32'(busy), 32'd0);
    drain(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
